// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, drives a synchronous-read instruction
// memory and presents one instruction per cycle to the decoder. A taken jump
// from the decoder redirects fetch and squashes the one wrong-path word.
module instruction_fetch_unit #(
   parameter int unsigned INSTRUCTION_WIDTH = 16,
   parameter int unsigned PC_VALUE_WIDTH    = 5,
   // Bubble word: zero-extended NOP opcode (low nibble holds the opcode)
   parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = INSTRUCTION_WIDTH'(4'h0)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         halt,
   input  logic                         stall,
   input  logic                         PC_jump_enable,
   input  logic [PC_VALUE_WIDTH-1:0]    PC_jump_value,
   output logic                         imem_en,
   output logic [PC_VALUE_WIDTH-1:0]    imem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         instruction_valid,
   output logic [PC_VALUE_WIDTH-1:0]    pc,
   output logic                         busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]                   state, state_nxt;
   logic [PC_VALUE_WIDTH-1:0]    fetch_pc, fetch_pc_nxt;
   // Address issued on the last enabled cycle, i.e. the source of imem_rdata
   logic [PC_VALUE_WIDTH-1:0]    rd_addr, rd_addr_nxt;
   logic [PC_VALUE_WIDTH-1:0]    issue_addr;
   logic [INSTRUCTION_WIDTH-1:0] ir_nxt;
   logic [PC_VALUE_WIDTH-1:0]    pc_nxt;
   logic                         valid_nxt;

   assign busy = (state != ST_IDLE);

   // Next-state, next-IR and memory request decode (halt > stall > jump > sequential)
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      rd_addr_nxt  = rd_addr;
      ir_nxt       = instruction;
      pc_nxt       = pc;
      valid_nxt    = instruction_valid;
      issue_addr   = fetch_pc;
      imem_en      = 1'b0;
      imem_addr    = rd_addr;

      case (state)
         ST_IDLE: begin
            imem_addr = '0;
            if (start && !halt) begin
               imem_en      = 1'b1;
               rd_addr_nxt  = '0;
               fetch_pc_nxt = PC_VALUE_WIDTH'(1);
               state_nxt    = ST_FILL;
            end
         end
         ST_FILL, ST_RUN: begin
            if (halt) begin
               state_nxt    = ST_IDLE;
               fetch_pc_nxt = '0;
               rd_addr_nxt  = '0;
               ir_nxt       = NOP_WORD;
               pc_nxt       = '0;
               valid_nxt    = 1'b0;
            end else if (!stall) begin
               // Taken jump: redirect now, drop the sequential word in imem_rdata
               if (state == ST_RUN && instruction_valid && PC_jump_enable) begin
                  issue_addr = PC_jump_value;
                  ir_nxt     = NOP_WORD;
                  valid_nxt  = 1'b0;
               end else begin
                  ir_nxt     = imem_rdata;
                  pc_nxt     = rd_addr;
                  valid_nxt  = 1'b1;
               end
               imem_en      = 1'b1;
               imem_addr    = issue_addr;
               rd_addr_nxt  = issue_addr;
               fetch_pc_nxt = issue_addr + PC_VALUE_WIDTH'(1);
               state_nxt    = ST_RUN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // No memory traffic while reset is being applied
      if (rst) imem_en = 1'b0;
   end

   // State, PC and instruction register update
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         fetch_pc          <= '0;
         rd_addr           <= '0;
         instruction       <= NOP_WORD;
         instruction_valid <= 1'b0;
         pc                <= '0;
      end else begin
         state             <= state_nxt;
         fetch_pc          <= fetch_pc_nxt;
         rd_addr           <= rd_addr_nxt;
         instruction       <= ir_nxt;
         instruction_valid <= valid_nxt;
         pc                <= pc_nxt;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: synchronous memory model, toy decoder,
// program-order reference model feeding a scoreboard, directed and random phases.
module tb_instruction_fetch_unit;

   localparam int unsigned IW    = 16;
   localparam int unsigned PW    = 5;
   localparam int unsigned DEPTH = 32;
   localparam logic [IW-1:0] NOP = 16'h0000;

   logic          clk = 1'b0;
   logic          rst, start, halt, stall, spurious;
   logic          PC_jump_enable;
   logic [PW-1:0] PC_jump_value;
   logic          imem_en;
   logic [PW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic [IW-1:0] instruction;
   logic          instruction_valid;
   logic [PW-1:0] pc;
   logic          busy;

   logic [IW-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          v;
      logic [PW-1:0] pc;
      logic [IW-1:0] w;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_e;

   instruction_fetch_unit #(
      .INSTRUCTION_WIDTH(IW),
      .PC_VALUE_WIDTH(PW),
      .NOP_WORD(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .halt(halt),
      .stall(stall),
      .PC_jump_enable(PC_jump_enable),
      .PC_jump_value(PC_jump_value),
      .imem_en(imem_en),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .instruction(instruction),
      .instruction_valid(instruction_valid),
      .pc(pc),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   // Toy decoder: top nibble F is JUMP to low 5 bits; 'spurious' raises enable on bubbles
   function automatic logic is_jump(input logic [IW-1:0] w);
      return w[15:12] == 4'hF;
   endfunction

   assign PC_jump_enable = is_jump(instruction) | (spurious & ~instruction_valid);
   assign PC_jump_value  = instruction[PW-1:0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: program order from address 0 (JUMP -> bubble then target, else +1 mod depth)
   task automatic push_run(input int n);
      int cur = 0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{1'b1, PW'(cur), mem[cur]});
         if (is_jump(mem[cur])) begin
            exp_q.push_back('{1'b0, PW'(0), NOP});
            cur = int'(mem[cur][PW-1:0]);
         end else begin
            cur = (cur + 1) % DEPTH;
         end
      end
   endtask

   // Monitor: sample pre-edge control at negedge, compare after the following posedge
   logic mon_adv = 1'b0;
   logic mon_stl = 1'b0;
   logic mon_en  = 1'b0;

   always @(negedge clk) begin
      mon_adv = busy && !stall && !halt && !rst;
      mon_stl = busy &&  stall && !halt && !rst;
      mon_en  = imem_en;
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (mon_stl) begin
         check("stall_imem_en", 32'(mon_en), 32'(0));
         check("stall_ir_hold", 32'(instruction), 32'(last_e.w));
         check("stall_valid_hold", 32'(instruction_valid), 32'(last_e.v));
      end
      if (mon_adv) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=presentation required=none at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_valid", 32'(instruction_valid), 32'(e.v));
            check("sb_instr", 32'(instruction), 32'(e.w));
            if (e.v) check("sb_pc", 32'(pc), 32'(e.pc));
            last_e = e;
         end
      end
   end

   task automatic check_idle(input string tag);
      #1;
      check({tag, "_instr"}, 32'(instruction), 32'(NOP));
      check({tag, "_valid"}, 32'(instruction_valid), 32'(0));
      check({tag, "_pc"}, 32'(pc), 32'(0));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_imem_en"}, 32'(imem_en), 32'(0));
      check({tag, "_imem_addr"}, 32'(imem_addr), 32'(0));
   endtask

   task automatic do_start();
      exp_q.delete();
      last_e = '{1'b0, PW'(0), NOP};
      push_run(150);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_halt(input string tag);
      halt = 1'b1;
      tick();
      halt  = 1'b0;
      stall = 1'b0;
      exp_q.delete();
      check_idle(tag);
   endtask

   task automatic wait_pc(input int p, input int maxc);
      bit found = 1'b0;
      for (int i = 0; i < maxc && !found; i++) begin
         tick();
         if (instruction_valid && pc == PW'(p)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_pc actual=pc%0d required=pc%0d within %0d cycles", pc, p, maxc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IW-1:0] w;
      int            ncyc;
      rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0; spurious = 1'b0;
      imem_rdata = '0;
      last_e = '{1'b0, PW'(0), NOP};
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0100 + IW'(i);
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");

      // Phase A: sequential fetch, 3-cycle stall on mem[5], wrap 30,31,0,1
      do_start();
      #1;
      check("fill_valid", 32'(instruction_valid), 32'(0));
      check("fill_busy", 32'(busy), 32'(1));
      tick();
      check("first_instr", 32'(instruction), 32'h0100);
      check("first_pc", 32'(pc), 32'(0));
      wait_pc(5, 10);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall5_en", 32'(imem_en), 32'(0));
         check("stall5_instr", 32'(instruction), 32'h0105);
         check("stall5_pc", 32'(pc), 32'(5));
         tick();
      end
      stall = 1'b0;
      tick();
      check("after_stall_instr", 32'(instruction), 32'h0106);
      wait_pc(30, 60);
      tick();
      check("wrap_pc31", 32'(pc), 32'(31));
      tick();
      check("wrap_pc0", 32'(pc), 32'(0));
      check("wrap_valid", 32'(instruction_valid), 32'(1));
      tick();
      check("wrap_pc1", 32'(pc), 32'(1));
      do_halt("halt");

      // Phase B: jumps 3->20 and 22->9, stall on a pending jump, reset at pc 12
      mem[3]  = 16'hF014;
      mem[22] = 16'hF009;
      spurious = 1'b1;
      do_start();
      wait_pc(3, 10);
      check("j3_instr", 32'(instruction), 32'hF014);
      tick();
      check("j3_bubble_valid", 32'(instruction_valid), 32'(0));
      check("j3_bubble_instr", 32'(instruction), 32'(NOP));
      tick();
      check("j3_target_pc", 32'(pc), 32'(20));
      check("j3_target_instr", 32'(instruction), 32'h0114);
      tick();
      check("j3_next_pc", 32'(pc), 32'(21));
      wait_pc(22, 5);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("jstall_instr", 32'(instruction), 32'hF009);
         check("jstall_addr", 32'(imem_addr), 32'(23));
         check("jstall_en", 32'(imem_en), 32'(0));
         tick();
      end
      stall = 1'b0;
      #1;
      check("jtaken_addr", 32'(imem_addr), 32'(9));
      tick();
      check("j22_bubble_valid", 32'(instruction_valid), 32'(0));
      tick();
      check("j22_target_pc", 32'(pc), 32'(9));
      check("j22_target_instr", 32'(instruction), 32'h0109);
      wait_pc(12, 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check_idle("rst_run");
      do_start();
      tick();
      check("restart_instr", 32'(instruction), 32'h0100);
      check("restart_pc", 32'(pc), 32'(0));
      check("restart_valid", 32'(instruction_valid), 32'(1));
      do_halt("halt_b");

      // Phase C: random programs, random stalls and spurious enables, halt at a random point
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(3) == 0) begin
               mem[i] = {4'hF, 7'h00, PW'($urandom_range(DEPTH - 1))};
            end else begin
               w = IW'($urandom);
               if (w[15:12] == 4'hF) w[15:12] = 4'h0;
               mem[i] = w;
            end
         end
         do_start();
         ncyc = 60 + int'($urandom_range(40));
         for (int c = 0; c < ncyc; c++) begin
            stall    = ($urandom_range(3) == 0);
            spurious = 1'($urandom_range(1));
            tick();
         end
         stall = 1'($urandom_range(1));
         do_halt("halt_rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
